cozy_mem_arbiter: RTL and testbench

//  Parametrised N-channel arbitrated word RAM, the successor to the single-port cozy memory model.

---
 rtl/cozy_mem_arbiter_pkg.sv | 17 +
 rtl/cozy_rr_arbiter.sv | 27 ++
 rtl/cozy_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_cozy_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cozy_mem_arbiter_pkg.sv
// Shared types for the cozy arbitrated word RAM: FSM encodings and channel helpers.
package cozy_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int GRANT_W = 3;
    localparam int MAX_CHAN = 8;

    function automatic logic [MAX_CHAN-1:0] chan_onehot(input logic [GRANT_W-1:0] idx);
        return MAX_CHAN'(1) << idx;
    endfunction

endpackage

// File: rtl/cozy_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after the pointer, cyclically.
module cozy_rr_arbiter
    import cozy_mem_arbiter_pkg::*;
#(
    parameter int NCHAN = 2
) (
    input  logic [NCHAN-1:0]   req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] gnt_idx,
    output logic               gnt_valid
);

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        // Scan ptr+1 .. ptr+NCHAN so the last-served channel has lowest priority.
        for (int k = 1; k <= NCHAN; k++) begin
            int c;
            c = (int'(ptr) + k) % NCHAN;
            if (!gnt_valid && req[c]) begin
                gnt_valid = 1'b1;
                gnt_idx   = GRANT_W'(c);
            end
        end
    end

endmodule

// File: rtl/cozy_mem_arbiter.sv
// N-channel round-robin arbitrated byte-lane word RAM with wait states and req/ack handshake.
// Define COZY_MEM_BOUNDS_EN to add the err output and out-of-range access suppression.
module cozy_mem_arbiter
    import cozy_mem_arbiter_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 12,
    parameter int NCHAN      = 2,
    parameter int WAIT       = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NCHAN-1:0]              req,
    input  logic [NCHAN*ADDR_W-1:0]       addr,
    input  logic [NCHAN*(DATA_W/8)-1:0]   bwe,
    input  logic [NCHAN*DATA_W-1:0]       din,
    output logic [NCHAN-1:0]              ack,
    output logic [DATA_W-1:0]             dout,
    output logic [GRANT_W-1:0]            grant
`ifdef COZY_MEM_BOUNDS_EN
    ,
    output logic [NCHAN-1:0]              err
`endif
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    state_e               state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [GRANT_W-1:0]   ptr_q, ptr_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic [NCHAN-1:0]     ack_q, ack_d;

    logic [GRANT_W-1:0]   arb_idx;
    logic                 arb_valid;
    logic [MAX_CHAN-1:0]  grant_oh_full;
    logic [NCHAN-1:0]     grant_oh;

    logic [ADDR_W-1:0]    sel_addr;
    logic [NB-1:0]        sel_bwe;
    logic [DATA_W-1:0]    sel_din;
    logic [DEPTH_LOG2-1:0] widx;
    logic                 addr_hi_nz;
    logic                 oob;
    logic                 access;
    logic                 rd_en;
    logic                 unused_addr_bits;

    cozy_rr_arbiter #(
        .NCHAN (NCHAN)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign grant_oh_full = chan_onehot(grant_q);
    assign grant_oh      = grant_oh_full[NCHAN-1:0];

    always_comb begin
        sel_addr = '0;
        sel_bwe  = '0;
        sel_din  = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (grant_q == GRANT_W'(c)) begin
                sel_addr = addr[c*ADDR_W +: ADDR_W];
                sel_bwe  = bwe[c*NB +: NB];
                sel_din  = din[c*DATA_W +: DATA_W];
            end
        end
    end

    // addr[0] selects a byte within the word and is not used for word access.
    assign widx = sel_addr[DEPTH_LOG2:1];

    generate
        if (ADDR_W > DEPTH_LOG2 + 1) begin : g_hi
            assign addr_hi_nz = |sel_addr[ADDR_W-1:DEPTH_LOG2+1];
        end else begin : g_no_hi
            assign addr_hi_nz = 1'b0;
        end
    endgenerate

`ifdef COZY_MEM_BOUNDS_EN
    assign oob = addr_hi_nz;
`else
    assign oob = 1'b0;
`endif
    assign unused_addr_bits = ^{sel_addr[0], addr_hi_nz};

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wcnt_d  = wcnt_q;
        ack_d   = '0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    wcnt_d  = 4'(WAIT);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    ack_d   = grant_oh;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_d   = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= GRANT_W'(NCHAN - 1);
            wcnt_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wcnt_q  <= wcnt_d;
            ack_q   <= ack_d;
        end
    end

    assign rd_en = access && !oob && !(|sel_bwe);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] lane_q;
            logic       lane_we;

            // Reset blocks the access edge so a pending write is dropped.
            assign lane_we = access && !reset && !oob && sel_bwe[gi];

            always_ff @(posedge clk) begin
                if (lane_we) begin
                    mem[widx] <= sel_din[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_q <= '0;
                end else if (access && oob) begin
                    lane_q <= '0;
                end else if (rd_en) begin
                    lane_q <= mem[widx];
                end
            end

            assign dout[gi*8 +: 8] = lane_q;
        end
    endgenerate

`ifdef COZY_MEM_BOUNDS_EN
    logic [NCHAN-1:0] err_q, err_d;

    assign err_d = (access && oob) ? grant_oh : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign ack   = ack_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_cozy_mem_arbiter.sv
// Directed bench for cozy_mem_arbiter: table-driven single accesses plus arbitration/wait/reset sequences.
module tb_cozy_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] addr;
    logic [3:0]  bwe;
    logic [31:0] din;

    logic [1:0]  ack0, ack1;
    logic [15:0] dout0, dout1;
    logic [2:0]  grant0, grant1;
`ifdef COZY_MEM_BOUNDS_EN
    logic [1:0]  err0, err1;
`endif

    int total = 0;
    int bad   = 0;

    cozy_mem_arbiter u_dut (
        .clk   (clk),
        .reset (rst),
        .req   (req),
        .addr  (addr),
        .bwe   (bwe),
        .din   (din),
        .ack   (ack0),
        .dout  (dout0),
        .grant (grant0)
`ifdef COZY_MEM_BOUNDS_EN
        ,
        .err   (err0)
`endif
    );

    cozy_mem_arbiter #(
        .WAIT (3)
    ) u_dut_w3 (
        .clk   (clk),
        .reset (rst),
        .req   (req),
        .addr  (addr),
        .bwe   (bwe),
        .din   (din),
        .ack   (ack1),
        .dout  (dout1),
        .grant (grant1)
`ifdef COZY_MEM_BOUNDS_EN
        ,
        .err   (err1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_access(input int which, input int ch, input logic [15:0] a,
                             input logic [1:0] b, input logic [15:0] d,
                             output logic [15:0] rd, output int lat,
                             output logic [2:0] gr, output logic er);
        logic [1:0] ak;
        logic       got;
        @(negedge clk);
        req[ch]          = 1'b1;
        addr[ch*16 +: 16] = a;
        bwe[ch*2 +: 2]   = b;
        din[ch*16 +: 16] = d;
        lat = 0;
        got = 1'b0;
        rd  = '0;
        gr  = '0;
        er  = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            ak = (which == 0) ? ack0 : ack1;
            if (ak[ch]) begin
                got = 1'b1;
                rd  = (which == 0) ? dout0 : dout1;
                gr  = (which == 0) ? grant0 : grant1;
`ifdef COZY_MEM_BOUNDS_EN
                er  = (which == 0) ? err0[ch] : err1[ch];
`endif
            end
        end
        req[ch] = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
        if (got) begin
            @(negedge clk);
            ak = (which == 0) ? ack0 : ack1;
            chk("ack_one_cycle", 32'(ak[ch]), 32'd0);
        end
    endtask

    typedef struct {
        int          ch;
        logic [15:0] a;
        logic [1:0]  b;
        logic [15:0] d;
        logic [15:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [15:0] rd;
        int          lat;
        logic [2:0]  gr;
        logic        er;
        int          nack;
        int          cyc;
        int          a0_cyc, a1_cyc;
        logic [15:0] d0;
        logic [2:0]  g1;
        logic [1:0]  exp_ack;
        logic        seen;

        // ch, addr, bwe, din, expected dout at ack, expected err
        vecs.push_back('{0, 16'h0040, 2'b11, 16'h1234, 16'h0000, 1'b0});
        vecs.push_back('{0, 16'h0040, 2'b00, 16'h0000, 16'h1234, 1'b0});
        vecs.push_back('{0, 16'h0040, 2'b10, 16'hAB00, 16'h1234, 1'b0});
        vecs.push_back('{0, 16'h0040, 2'b00, 16'h0000, 16'hAB34, 1'b0});
        vecs.push_back('{0, 16'h0040, 2'b01, 16'h00CD, 16'hAB34, 1'b0});
        vecs.push_back('{0, 16'h0040, 2'b00, 16'h0000, 16'hABCD, 1'b0});
        vecs.push_back('{1, 16'h0100, 2'b11, 16'hBEEF, 16'hABCD, 1'b0});
        vecs.push_back('{1, 16'h0100, 2'b00, 16'h0000, 16'hBEEF, 1'b0});
        vecs.push_back('{0, 16'h0041, 2'b00, 16'h0000, 16'hABCD, 1'b0});
        vecs.push_back('{0, 16'h0000, 2'b11, 16'h1111, 16'hABCD, 1'b0});
`ifdef COZY_MEM_BOUNDS_EN
        vecs.push_back('{0, 16'h2000, 2'b11, 16'h7777, 16'h0000, 1'b1});
        vecs.push_back('{1, 16'h0000, 2'b00, 16'h0000, 16'h1111, 1'b0});
`else
        vecs.push_back('{0, 16'h2000, 2'b11, 16'h7777, 16'hABCD, 1'b0});
        vecs.push_back('{1, 16'h0000, 2'b00, 16'h0000, 16'h7777, 1'b0});
`endif

        rst  = 1'b1;
        req  = '0;
        addr = '0;
        bwe  = '0;
        din  = '0;
        repeat (3) @(negedge clk);
        chk("reset_ack", 32'(ack0), 32'd0);
        chk("reset_dout", 32'(dout0), 32'd0);
        chk("reset_grant", 32'(grant0), 32'd0);
        chk("reset_ack_w3", 32'(ack1), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_access(0, vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].d, rd, lat, gr, er);
            $display("vec %0d: ch=%0d addr=%h bwe=%b din=%h -> dout=%h lat=%0d grant=%0d err=%0b",
                     i, vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].d, rd, lat, gr, er);
            chk("vec_latency", 32'(lat), 32'd2);
            chk("vec_dout", 32'(rd), 32'(vecs[i].exp_dout));
            chk("vec_grant", 32'(gr), 32'(vecs[i].ch));
            chk("vec_err", 32'(er), 32'(vecs[i].exp_err));
        end

        // Both channels hold req: strict alternation starting at channel 0.
        pulse_reset();
        @(negedge clk);
        req  = 2'b11;
        addr = {16'h0040, 16'h0040};
        bwe  = '0;
        nack = 0;
        cyc  = 0;
        while (nack < 4 && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (|ack0) begin
                exp_ack = (nack % 2 == 0) ? 2'b01 : 2'b10;
                $display("rr: cycle=%0d ack=%b grant=%0d", cyc, ack0, grant0);
                chk("rr_ack", 32'(ack0), 32'(exp_ack));
                chk("rr_cycle", 32'(cyc), 32'(2 + 3 * nack));
                nack++;
            end
        end
        req = '0;
        chk("rr_count", 32'(nack), 32'd4);

        // WAIT=3 instance: ch0 read, ch1 arrives mid-access and waits for DONE.
        pulse_reset();
        do_access(1, 0, 16'h0010, 2'b11, 16'hCAFE, rd, lat, gr, er);
        $display("w3 write: lat=%0d", lat);
        chk("w3_write_latency", 32'(lat), 32'd5);
        @(negedge clk);
        req[0]       = 1'b1;
        addr[15:0]   = 16'h0010;
        bwe[1:0]     = 2'b00;
        addr[31:16]  = 16'h0010;
        bwe[3:2]     = 2'b00;
        cyc    = 0;
        a0_cyc = -1;
        a1_cyc = -1;
        d0     = '0;
        g1     = '0;
        while ((a0_cyc < 0 || a1_cyc < 0) && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 2) req[1] = 1'b1;
            if (ack1[0] && a0_cyc < 0) begin
                a0_cyc = cyc;
                d0     = dout1;
                req[0] = 1'b0;
            end
            if (ack1[1] && a1_cyc < 0) begin
                a1_cyc = cyc;
                g1     = grant1;
                req[1] = 1'b0;
            end
        end
        req = '0;
        $display("w3 read: ch0 ack at %0d dout=%h, ch1 ack at %0d grant=%0d", a0_cyc, d0, a1_cyc, g1);
        chk("w3_ch0_latency", 32'(a0_cyc), 32'd5);
        chk("w3_ch0_dout", 32'(d0), 32'hCAFE);
        chk("w3_ch1_latency", 32'(a1_cyc), 32'd11);
        chk("w3_ch1_grant", 32'(g1), 32'd1);

        // Reset during BUSY drops the pending write and suppresses ack.
        pulse_reset();
        do_access(0, 0, 16'h0080, 2'b11, 16'h5555, rd, lat, gr, er);
        do_access(0, 0, 16'h0080, 2'b00, 16'h0000, rd, lat, gr, er);
        chk("rst_pre_read", 32'(rd), 32'h5555);
        @(negedge clk);
        req[0]     = 1'b1;
        addr[15:0] = 16'h0080;
        bwe[1:0]   = 2'b11;
        din[15:0]  = 16'hAAAA;
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_dout", 32'(dout0), 32'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | (|ack0);
        end
        $display("reset mid-busy: ack_seen=%0b", seen);
        chk("rst_mid_no_ack", 32'(seen), 32'd0);
        do_access(0, 0, 16'h0080, 2'b00, 16'h0000, rd, lat, gr, er);
        $display("reset mid-busy readback: dout=%h", rd);
        chk("rst_mid_readback", 32'(rd), 32'h5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
